// File: rtl/multdiv_issue_control_pkg.sv
// multdiv_issue_control_pkg: opcode/ALU-op constants, FSM encoding and decode helpers
// shared by the mul/div issue control.
package multdiv_issue_control_pkg;
    localparam logic [4:0] OP_ALU = 5'd0, OP_BNE = 5'd2, OP_JAL = 5'd3, OP_ADDI = 5'd5;
    localparam logic [4:0] OP_BLT = 5'd6, OP_SW = 5'd7, OP_LW = 5'd8;
    localparam logic [4:0] ALU_MUL = 5'b00110, ALU_DIV = 5'b00111;
    localparam logic [4:0] REG_RA = 5'd31;
    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;
    function automatic logic is_muldiv(input logic [31:0] ir);
        return ir[31:27] == OP_ALU && (ir[6:2] == ALU_MUL || ir[6:2] == ALU_DIV);
    endfunction
    // An all-zero word is the pipeline nop and never occupies the write port.
    function automatic logic writes_w(input logic [31:0] ir);
        return ir != 32'd0 && (ir[31:27] == OP_ALU || ir[31:27] == OP_JAL ||
                               ir[31:27] == OP_ADDI || ir[31:27] == OP_LW);
    endfunction
endpackage

// File: rtl/multdiv_issue_control_if.sv
// multdiv_issue_control_if: start/operand/result handshake between issue control and mul/div datapath.
interface multdiv_issue_control_if;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        data_resultRDY;
    logic        data_exception;
    logic [31:0] data_result;
    modport master(output ctrl_MULT, ctrl_DIV, operandA, operandB,
                   input data_resultRDY, data_exception, data_result);
    modport slave(input ctrl_MULT, ctrl_DIV, operandA, operandB,
                  output data_resultRDY, data_exception, data_result);
endinterface

// File: rtl/multdiv_issue_control_hazard.sv
// pw_hazard_detect: flags an X-stage instruction that reads or writes the register held in the P/W latch.
module pw_hazard_detect
    import multdiv_issue_control_pkg::*;
(
    input  logic [4:0] op,
    input  logic [4:0] rd,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [4:0] pw_rd,
    output logic       hit
);
    always_comb begin
        hit = 1'b0;
        if (pw_rd != 5'd0)
            case (op)
                OP_ALU: hit = rd == pw_rd || rs == pw_rd || rt == pw_rd;
                OP_BNE, OP_ADDI, OP_BLT, OP_SW, OP_LW: hit = rd == pw_rd || rs == pw_rd;
                OP_JAL: hit = pw_rd == REG_RA;
                default: hit = 1'b0;
            endcase
    end
endmodule

// File: rtl/multdiv_issue_control.sv
// multdiv_issue_control: issues mul/div from X to the datapath, holds the result in the P/W latch
// and steals a W-stage slot for writeback, stalling dependent or competing instructions.
module multdiv_issue_control
    import multdiv_issue_control_pkg::*;
#(
    parameter logic [4:0]  RSTATUS_REG  = 5'd30,
    parameter logic [31:0] MUL_EXC_CODE = 32'd4,
    parameter logic [31:0] DIV_EXC_CODE = 32'd5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] DXIR,
    input  logic [31:0] DXA,
    input  logic [31:0] DXB,
    input  logic [31:0] MWIR,
    output logic [31:0] PWIR,
    output logic [31:0] PWResult,
    output logic        multOrDivReady,
    output logic        stall,
    multdiv_issue_control_if.master dp
);
    state_t state, state_nx;
    logic dx_md, hazard, capture, pw_mul;
    assign dx_md  = is_muldiv(DXIR);
    assign pw_mul = PWIR[6:2] == ALU_MUL;
    pw_hazard_detect u_hazard (
        .op(DXIR[31:27]),
        .rd(DXIR[26:22]),
        .rs(DXIR[21:17]),
        .rt(DXIR[16:12]),
        .pw_rd(PWIR[26:22]),
        .hit(hazard)
    );
    always_comb begin
        multOrDivReady = reset_n && state == DONE && !writes_w(MWIR);
        stall = reset_n && state != IDLE &&
                ((dx_md && !multOrDivReady) || hazard || (state == DONE && !multOrDivReady));
        capture = dx_md && !stall && (state == IDLE || multOrDivReady);
        dp.ctrl_MULT = reset_n && state == START && pw_mul;
        dp.ctrl_DIV = reset_n && state == START && !pw_mul;
        state_nx = capture ? START :
                   state == START ? BUSY :
                   state == BUSY && dp.data_resultRDY ? DONE :
                   multOrDivReady ? IDLE : state;
    end
    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // Writeback clears PWIR; a back-to-back capture on the same edge takes priority.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            PWIR        <= '0;
            PWResult    <= '0;
            dp.operandA <= '0;
            dp.operandB <= '0;
        end else begin
            if (capture) begin
                PWIR        <= DXIR;
                dp.operandA <= DXA;
                dp.operandB <= DXB;
            end else if (multOrDivReady) begin
                PWIR <= '0;
            end
            if (state == BUSY && dp.data_resultRDY) begin
                PWResult <= dp.data_exception ? (pw_mul ? MUL_EXC_CODE : DIV_EXC_CODE) : dp.data_result;
                if (dp.data_exception)
                    PWIR[26:22] <= RSTATUS_REG;
            end
        end
    end
endmodule

// File: tb/tb_multdiv_issue_control.sv
// tb_multdiv_issue_control: directed scenarios plus randomized traffic checked against a
// transaction-level model of the issue/writeback rules.
module tb_multdiv_issue_control;
    localparam logic [4:0] ALU = 5'd0, BNE = 5'd2, JAL = 5'd3, ADDI = 5'd5, BLT = 5'd6, SW = 5'd7, LW = 5'd8;
    localparam logic [4:0] MUL = 5'b00110, DIV = 5'b00111;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] DXIR = '0, DXA = '0, DXB = '0, MWIR = '0;
    logic [31:0] PWIR, PWResult;
    logic        multOrDivReady, stall;
    int          errors = 0, checks = 0;
    multdiv_issue_control_if dp();
    multdiv_issue_control dut (
        .clock(clock),
        .reset_n(reset_n),
        .DXIR(DXIR),
        .DXA(DXA),
        .DXB(DXB),
        .MWIR(MWIR),
        .PWIR(PWIR),
        .PWResult(PWResult),
        .multOrDivReady(multOrDivReady),
        .stall(stall),
        .dp(dp)
    );
    always #5 clock = ~clock;

    // Model: an in-flight operation with its age in cycles since capture and whether its result arrived.
    logic [31:0] m_ir = '0, m_a = '0, m_b = '0, m_res = '0;
    int          m_age = -1;
    bit          m_done = 0, m_stall = 0, m_ctrl = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic bit writes_reg(input logic [31:0] ir);
        return ir != 0 && ir[31:27] inside {ALU, JAL, ADDI, LW};
    endfunction

    function automatic bit touches(input logic [31:0] ir, input logic [4:0] r);
        logic [4:0] regs[$];
        if (r == 0) return 0;
        if (ir[31:27] == ALU) begin
            regs.push_back(ir[26:22]); regs.push_back(ir[21:17]); regs.push_back(ir[16:12]);
        end else if (ir[31:27] inside {BNE, ADDI, BLT, SW, LW}) begin
            regs.push_back(ir[26:22]); regs.push_back(ir[21:17]);
        end else if (ir[31:27] == JAL) begin
            regs.push_back(5'd31);
        end
        foreach (regs[i]) if (regs[i] == r) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] rnd_ir();
        logic [4:0] rd = 5'($urandom_range(0, 7));
        logic [4:0] rs = 5'($urandom_range(0, 7));
        logic [4:0] rt = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 10))
            0: return 32'd0;
            1, 2: return mk(ALU, rd, rs, rt, MUL);
            3: return mk(ALU, rd, rs, rt, DIV);
            4: return mk(ALU, rd, rs, rt, 5'd0);
            5: return mk(BNE, rd, rs, rt, 5'd0);
            6: return {JAL, 27'($urandom)};
            7: return mk(ADDI, rd, rs, rt, 5'd0);
            8: return mk(BLT, rd, rs, rt, 5'd0);
            9: return mk(SW, rd, rs, rt, 5'd0);
            default: return mk(LW, rd, rs, rt, 5'd0);
        endcase
    endfunction

    // Check outputs for the current cycle, advance the model across the edge, return at the next negedge.
    task automatic step();
        bit busy, md, rdy, haz;
        #1;
        busy = m_age >= 0;
        md   = DXIR[31:27] == ALU && (DXIR[6:2] == MUL || DXIR[6:2] == DIV);
        rdy  = reset_n && busy && m_done && !writes_reg(MWIR);
        haz  = busy && touches(DXIR, m_ir[26:22]);
        m_stall = reset_n && busy && ((md && !rdy) || haz || (m_done && !rdy));
        m_ctrl  = reset_n && busy && m_age == 0;
        check("ready", multOrDivReady, rdy);
        check("stall", stall, m_stall);
        check("ctrl_mult", dp.ctrl_MULT, m_ctrl && m_ir[6:2] == MUL);
        check("ctrl_div", dp.ctrl_DIV, m_ctrl && m_ir[6:2] == DIV);
        check("pwir", PWIR, m_ir);
        check("pwresult", PWResult, m_res);
        check("opa", dp.operandA, m_a);
        check("opb", dp.operandB, m_b);
        if (!reset_n) begin
            m_ir = 0; m_a = 0; m_b = 0; m_res = 0; m_age = -1; m_done = 0;
        end else begin
            if (busy && rdy) begin
                m_ir = 0; m_age = -1; m_done = 0;
            end else if (busy) begin
                if (m_age >= 1 && !m_done && dp.data_resultRDY) begin
                    m_done = 1;
                    m_res  = dp.data_result;
                    if (dp.data_exception) begin
                        m_res = m_ir[6:2] == MUL ? 32'd4 : 32'd5;
                        m_ir[26:22] = 5'd30;
                    end
                end
                m_age++;
            end
            if (md && !m_stall && (!busy || rdy)) begin
                m_ir = DXIR; m_a = DXA; m_b = DXB; m_age = 0; m_done = 0;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic quiet();
        DXIR = 0; MWIR = 0;
        dp.data_resultRDY = 0; dp.data_exception = 0; dp.data_result = 0;
    endtask

    task automatic do_reset();
        quiet();
        reset_n = 0;
        step();
        step();
        reset_n = 1;
    endtask

    task automatic result(input logic [31:0] v, input bit exc);
        dp.data_resultRDY = 1; dp.data_exception = exc; dp.data_result = v;
        step();
        dp.data_resultRDY = 0; dp.data_exception = 0;
    endtask

    initial begin
        bit pend = 0;
        int lat = 0;
        quiet();
        @(posedge clock);
        @(negedge clock);
        do_reset();
        #1 check("rst_pwir", PWIR, 0);
        check("rst_stall", stall, 0);
        // mul r3,r1,r2 with 6*7, result five cycles after start
        DXIR = mk(ALU, 3, 1, 2, MUL); DXA = 6; DXB = 7;
        result(32'd99, 0);
        DXIR = 0;
        #1 check("mul_start", dp.ctrl_MULT, 1);
        repeat (5) step();
        result(32'd42, 0);
        #1 check("mul_ready", multOrDivReady, 1);
        check("mul_rd", PWIR[26:22], 3);
        check("mul_res", PWResult, 42);
        step();
        #1 check("mul_idle", PWIR, 0);
        check("mul_ready_off", multOrDivReady, 0);
        // div with exception
        DXIR = mk(ALU, 7, 1, 2, DIV); DXA = 9; DXB = 0;
        step();
        DXIR = 0;
        repeat (3) step();
        result(32'd123, 1);
        #1 check("div_exc_rd", PWIR[26:22], 30);
        check("div_exc_res", PWResult, 5);
        check("div_exc_ready", multOrDivReady, 1);
        step();
        // dependent vs independent add while mul r3 is in flight
        DXIR = mk(ALU, 3, 1, 2, MUL);
        step();
        DXIR = mk(ALU, 4, 3, 1, 5'd0);
        #1 check("dep_stall_start", stall, 1);
        step();
        DXIR = mk(ALU, 4, 5, 6, 5'd0);
        #1 check("indep_nostall", stall, 0);
        step();
        DXIR = mk(ALU, 4, 3, 1, 5'd0);
        #1 check("dep_stall_busy", stall, 1);
        result(32'd8, 0);
        #1 check("dep_stall_wb", stall, 1);
        step();
        #1 check("dep_released", stall, 0);
        DXIR = 0;
        // writeback blocked by lw in W
        DXIR = mk(ALU, 3, 1, 2, MUL);
        step();
        DXIR = 0;
        step();
        MWIR = mk(LW, 9, 1, 0, 5'd0);
        result(32'd77, 0);
        #1 check("lw_block_ready", multOrDivReady, 0);
        check("lw_block_stall", stall, 1);
        step();
        MWIR = 0;
        #1 check("lw_drain_ready", multOrDivReady, 1);
        step();
        // back-to-back mul then div
        DXIR = mk(ALU, 3, 1, 2, MUL); DXA = 3; DXB = 4;
        step();
        DXIR = mk(ALU, 5, 1, 2, DIV); DXA = 20; DXB = 4;
        step();
        result(32'd12, 0);
        #1 check("b2b_nostall", stall, 0);
        step();
        DXIR = 0;
        #1 check("b2b_div", dp.ctrl_DIV, 1);
        step();
        result(32'd5, 0);
        step();
        // reset mid-BUSY, then a late result
        DXIR = mk(ALU, 3, 1, 2, MUL);
        step();
        DXIR = 0;
        step();
        reset_n = 0;
        step();
        reset_n = 1;
        result(32'd42, 0);
        #1 check("late_pwir", PWIR, 0);
        check("late_ready", multOrDivReady, 0);
        step();
        // randomized traffic with a datapath of random latency
        for (int c = 0; c < 4000; c++) begin
            reset_n = $urandom_range(0, 249) != 0;
            dp.data_resultRDY = 0;
            dp.data_exception = 1'($urandom_range(0, 1));
            dp.data_result = $urandom;
            if (!reset_n) pend = 0;
            if (pend && lat == 0) begin
                dp.data_resultRDY = 1;
                dp.data_exception = $urandom_range(0, 4) == 0;
                pend = 0;
            end else if (pend) begin
                lat--;
            end else if ($urandom_range(0, 19) == 0) begin
                dp.data_resultRDY = 1;
            end
            MWIR = $urandom_range(0, 1) ? rnd_ir() : 32'd0;
            if (!m_stall) begin
                DXIR = rnd_ir();
                DXA = $urandom_range(0, 255);
                DXB = $urandom_range(0, 255);
            end
            step();
            if (m_ctrl) begin
                pend = 1;
                lat = $urandom_range(0, 5);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multdiv_issue_control.md
MULTDIV_ISSUE_CONTROL -- requirements
Module: multDivIssueControl

Interface
REQ-001 Parameter RSTATUS_REG, default 30, SHALL be the register written on a mul/div exception.
REQ-002 Parameter MUL_EXC_CODE, default 4, SHALL be the result value for a mul exception.
REQ-003 Parameter DIV_EXC_CODE, default 5, SHALL be the result value for a div exception.
REQ-004 Port clock, in, 1: single clock; all state updates on rising edge.
REQ-005 Port reset_n, in, 1: synchronous, active-low reset.
REQ-006 Port DXIR, in, 32: instruction in the X stage (opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2]).
REQ-007 Port DXA, in, 32 and DXB, in, 32: bypassed operands of DXIR.
REQ-008 Port MWIR, in, 32: instruction in the W stage.
REQ-009 Port data_resultRDY, in, 1; data_exception, in, 1; data_result, in, 32: from the mul/div datapath.
REQ-010 Port ctrl_MULT, out, 1 and ctrl_DIV, out, 1: start pulses to the datapath.
REQ-011 Port operandA, out, 32 and operandB, out, 32: latched datapath operands.
REQ-012 Port PWIR, out, 32: instruction held in the P/W latch.
REQ-013 Port PWResult, out, 32: value to write for PWIR.
REQ-014 Port multOrDivReady, out, 1: PWIR writes back this cycle.
REQ-015 Port stall, out, 1: freeze F/D and D/X and inject a nop into X/M.

Function
REQ-016 Mul/div SHALL be DXIR opcode 0 with ALU op 00110 (mul) or 00111 (div); W-writing opcodes SHALL be 0, 3, 5, 8.
REQ-017 States SHALL be IDLE, START, BUSY, DONE.
REQ-018 IDLE: mul/div in DX with stall low SHALL, on the edge, latch DXA/DXB to operandA/B, DXIR to PWIR, and move to START.
REQ-019 START: exactly one of ctrl_MULT/ctrl_DIV SHALL be high for exactly one cycle; then BUSY.
REQ-020 BUSY: data_resultRDY high SHALL latch data_result to PWResult and move to DONE.
REQ-021 BUSY with data_exception also high SHALL set PWResult to MUL_EXC_CODE/DIV_EXC_CODE and PWIR[26:22] to RSTATUS_REG.
REQ-022 DONE: multOrDivReady SHALL be high combinationally iff MWIR opcode is not a W-writing opcode; on that edge PWIR clears to 0 and state returns to IDLE.
REQ-023 multOrDivReady SHALL be low in every state except DONE.
REQ-024 stall SHALL be high when state is not IDLE and DXIR is mul/div, except in DONE with multOrDivReady high.
REQ-025 stall SHALL be high when state is not IDLE and DXIR reads or writes PWIR[26:22] (nonzero). Reads are rs/rt for ALU; rd/rs for opcodes 2, 6; rs/rd for 7, 8.
REQ-026 stall SHALL be high in DONE while multOrDivReady is low, so that bubbles drain the W slot within 2 cycles.
REQ-027 In DONE with multOrDivReady high, a mul/div in DX SHALL be captured on the same edge (back-to-back, state to START).
REQ-028 data_resultRDY outside BUSY SHALL be ignored.
REQ-029 Mul/div with rd = 0 SHALL still execute; its result is discarded downstream.

Reset
REQ-030 reset_n low at an edge SHALL force IDLE and set PWIR, PWResult, operandA, and operandB to 0. This applies in every state, including mid-BUSY.
REQ-031 During and after reset until the next capture, ctrl_MULT, ctrl_DIV, multOrDivReady, and stall SHALL be 0.

Structure
REQ-032 A shared package SHALL hold the opcode constants (ALU 0, BNE 2, JAL 3, ADDI 5, BLT 6, SW 7, LW 8), ALU op constants (MUL 00110, DIV 00111), and the state encoding.
REQ-033 The dependency compare SHALL be one combinational sub-module, pwHazardDetect.

Verification
REQ-034 mul r3,r1,r2 with A=6, B=7; datapath ready after 5 cycles -> ctrl_MULT pulses once; multOrDivReady high 1 cycle; PWIR rd=3; PWResult=42; then IDLE.
REQ-035 div with data_exception=1 -> PWIR[26:22]=30, PWResult=5, multOrDivReady high once.
REQ-036 add r4,r3,r1 enters DX while mul r3 is BUSY -> stall high until the writeback cycle; add r4,r5,r6 -> no stall.
REQ-037 Result ready while MWIR = lw (opcode 8) -> multOrDivReady low and stall high; asserted in the first cycle MWIR is a nop.
REQ-038 Back-to-back mul then div in DX -> div captured on the mul writeback edge; ctrl_DIV pulses the next cycle.
REQ-039 reset_n low mid-BUSY, then late data_resultRDY -> remains IDLE; PWIR=0; no multOrDivReady.
